// File: rtl/pc_mux_pkg.sv
// Shared types and constants for the fetch-stage next-PC selector.
// Used by pc_source_mux and pc_prio_enc.
package pc_mux_pkg;

    localparam int SEL_INC     = 0;
    localparam int DEFAULT_INC = 4;
    localparam int MAX_PC_W    = 64;
    localparam int MAX_IDX_W   = 8;

    function automatic int sel_width(input int num_src);
        return (num_src < 1) ? 1 : $clog2(num_src + 1);
    endfunction

    // Single-entry holding slot for a redirect seen while fetch is stalled.
    typedef struct packed {
        logic                 valid;
        logic [MAX_IDX_W-1:0] idx;
        logic [MAX_PC_W-1:0]  target;
    } pend_slot_t;

endpackage

// File: rtl/pc_prio_enc.sv
// Priority encoder over redirect requests: the highest set index wins.
module pc_prio_enc #(
    parameter int NUM_SRC = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (req[k]) begin
                found = 1'b1;
                idx   = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/pc_source_mux.sv
// Registered next-PC selector: increment, prioritised redirects, stall hold with one pending slot.
// Optional PC_SOURCE_MUX_ALIGN_CHECK_EN forces target bits [1:0] to zero and flags align_err.
module pc_source_mux
    import pc_mux_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               NUM_SRC      = 3,
    parameter int               INC          = DEFAULT_INC,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*WIDTH-1:0]      src_data,
    output logic [WIDTH-1:0]              pc_out,
    output logic                          pc_valid,
    output logic [sel_width(NUM_SRC)-1:0] sel_out,
    output logic                          redirect_pending
`ifdef PC_SOURCE_MUX_ALIGN_CHECK_EN
    ,
    output logic                          align_err
`endif
);

    localparam int SEL_W = sel_width(NUM_SRC);

    logic             live_found;
    logic [SEL_W-1:0] live_idx;
    logic [WIDTH-1:0] live_target;
    pend_slot_t       slot_p0;
    logic [SEL_W-1:0] slot_idx;
    logic [WIDTH-1:0] slot_target;
    logic             take_live;
    logic             win_found;
    logic [SEL_W-1:0] win_idx;
    logic [WIDTH-1:0] win_target;

    function automatic logic [WIDTH-1:0] align_target(input logic [WIDTH-1:0] t);
`ifdef PC_SOURCE_MUX_ALIGN_CHECK_EN
        return {t[WIDTH-1:2], 2'b00};
`else
        return t;
`endif
    endfunction

    pc_prio_enc #(
        .NUM_SRC(NUM_SRC),
        .IDX_W  (SEL_W)
    ) u_prio (
        .req  (src_valid),
        .found(live_found),
        .idx  (live_idx)
    );

    // Live request beats the slot only when its index is at least the slot's.
    always_comb begin
        live_target = src_data[int'(live_idx)*WIDTH +: WIDTH];
        slot_idx    = SEL_W'(slot_p0.idx);
        slot_target = WIDTH'(slot_p0.target);
        take_live   = live_found && (!slot_p0.valid || (live_idx >= slot_idx));
        win_found   = live_found || slot_p0.valid;
        win_idx     = take_live ? live_idx : slot_idx;
        win_target  = take_live ? live_target : slot_target;
    end

    assign redirect_pending = slot_p0.valid;

    // Stage p0 -> pc_out / slot
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out        <= RESET_VECTOR;
            pc_valid      <= 1'b0;
            sel_out       <= SEL_W'(SEL_INC);
            slot_p0.valid <= 1'b0;
`ifdef PC_SOURCE_MUX_ALIGN_CHECK_EN
            align_err     <= 1'b0;
`endif
        end else begin
            pc_valid  <= 1'b1;
`ifdef PC_SOURCE_MUX_ALIGN_CHECK_EN
            align_err <= 1'b0;
`endif
            if (stall) begin
                if (take_live) begin
                    slot_p0.valid  <= 1'b1;
                    slot_p0.idx    <= MAX_IDX_W'(live_idx);
                    slot_p0.target <= MAX_PC_W'(live_target);
                end
            end else begin
                slot_p0.valid <= 1'b0;
                if (win_found) begin
                    pc_out    <= align_target(win_target);
                    sel_out   <= win_idx + SEL_W'(1);
`ifdef PC_SOURCE_MUX_ALIGN_CHECK_EN
                    align_err <= |win_target[1:0];
`endif
                end else begin
                    pc_out  <= pc_out + WIDTH'(INC);
                    sel_out <= SEL_W'(SEL_INC);
                end
            end
        end
    end

endmodule
